// File: rtl/if_fetch_ctrl.sv
// Fetch-stage controller: next-PC selection, PC register, IF/ID latch with
// stall/flush handling, sticky HALT detection and a fetched-instruction counter.
module if_fetch_ctrl #(
    parameter int          N_BITS     = 32,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
    parameter logic [31:0] NOP_INSTR  = 32'h0,
    parameter int          CNT_BITS   = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_stall,
    input  logic                i_flush,
    input  logic [1:0]          i_pc_src,
    input  logic [N_BITS-1:0]   i_pc_4,
    input  logic [N_BITS-1:0]   i_branch_addr,
    input  logic [N_BITS-1:0]   i_jump_addr,
    input  logic [N_BITS-1:0]   i_jr_addr,
    input  logic [N_BITS-1:0]   i_instr,
    output logic [N_BITS-1:0]   o_pc,
    output logic [N_BITS-1:0]   o_if_id_pc_4,
    output logic [N_BITS-1:0]   o_if_id_instr,
    output logic                o_if_id_valid,
    output logic                o_halt,
    output logic [CNT_BITS-1:0] o_fetch_count
);

    localparam logic [1:0] SRC_SEQ    = 2'b00;
    localparam logic [1:0] SRC_BRANCH = 2'b01;
    localparam logic [1:0] SRC_JUMP   = 2'b10;
    localparam logic [1:0] SRC_JR     = 2'b11;

    localparam logic [N_BITS-1:0] PC_RST    = N_BITS'(RESET_PC);
    localparam logic [N_BITS-1:0] HALT_WORD = N_BITS'(HALT_INSTR);
    localparam logic [N_BITS-1:0] NOP_WORD  = N_BITS'(NOP_INSTR);

    logic [N_BITS-1:0]   pc_q, pc_d;
    logic [N_BITS-1:0]   if_id_pc_4_q, if_id_pc_4_d;
    logic [N_BITS-1:0]   if_id_instr_q, if_id_instr_d;
    logic                if_id_valid_q, if_id_valid_d;
    logic                halt_q, halt_d;
    logic [CNT_BITS-1:0] fetch_count_q, fetch_count_d;

    logic [N_BITS-1:0]   next_pc;
    logic                flush_en;
    logic                advance;
    logic                is_halt_instr;
    logic                fetch_en;

    always_comb begin
        next_pc = i_pc_4;
        case (i_pc_src)
            SRC_SEQ:    next_pc = i_pc_4;
            SRC_BRANCH: next_pc = i_branch_addr;
            SRC_JUMP:   next_pc = i_jump_addr;
            SRC_JR:     next_pc = i_jr_addr;
            default:    next_pc = i_pc_4;
        endcase
    end

    // Flush outranks stall and halt detection; a disabled cycle ignores everything.
    assign flush_en      = i_enable & i_flush;
    assign advance       = i_enable & ~i_stall & ~halt_q;
    assign is_halt_instr = (i_instr == HALT_WORD);
    assign fetch_en      = advance & ~flush_en;

    always_comb begin
        pc_d          = pc_q;
        if_id_pc_4_d  = if_id_pc_4_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        halt_d        = halt_q;
        fetch_count_d = fetch_count_q;

        if (flush_en) begin
            // A resolved redirect must land even while the hazard unit stalls.
            if (!halt_q) begin
                pc_d = next_pc;
            end
            if_id_pc_4_d  = '0;
            if_id_instr_d = NOP_WORD;
            if_id_valid_d = 1'b0;
        end else if (i_enable && halt_q) begin
            // Keep injecting bubbles so the latched HALT is not issued twice.
            if_id_pc_4_d  = '0;
            if_id_instr_d = NOP_WORD;
            if_id_valid_d = 1'b0;
        end else if (fetch_en) begin
            if_id_pc_4_d  = i_pc_4;
            if_id_instr_d = i_instr;
            if_id_valid_d = 1'b1;
            fetch_count_d = fetch_count_q + CNT_BITS'(1);
            if (is_halt_instr) begin
                halt_d = 1'b1;
            end else begin
                pc_d = next_pc;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pc_q          <= PC_RST;
            if_id_pc_4_q  <= '0;
            if_id_instr_q <= NOP_WORD;
            if_id_valid_q <= 1'b0;
            halt_q        <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_4_q  <= if_id_pc_4_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
            halt_q        <= halt_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign o_pc          = pc_q;
    assign o_if_id_pc_4  = if_id_pc_4_q;
    assign o_if_id_instr = if_id_instr_q;
    assign o_if_id_valid = if_id_valid_q;
    assign o_halt        = halt_q;
    assign o_fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a small instruction memory and PC+4 adder.
module tb_if_fetch_ctrl;

    localparam logic [31:0] IA = 32'h1111_1111;
    localparam logic [31:0] IB = 32'h2222_2222;
    localparam logic [31:0] IC = 32'h3333_3333;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic        i_stall;
    logic        i_flush;
    logic [1:0]  i_pc_src;
    logic [31:0] i_pc_4;
    logic [31:0] i_branch_addr;
    logic [31:0] i_jump_addr;
    logic [31:0] i_jr_addr;
    logic [31:0] i_instr;
    logic [31:0] o_pc;
    logic [31:0] o_if_id_pc_4;
    logic [31:0] o_if_id_instr;
    logic        o_if_id_valid;
    logic        o_halt;
    logic [15:0] o_fetch_count;

    int total = 0;
    int bad   = 0;

    if_fetch_ctrl dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_enable      (i_enable),
        .i_stall       (i_stall),
        .i_flush       (i_flush),
        .i_pc_src      (i_pc_src),
        .i_pc_4        (i_pc_4),
        .i_branch_addr (i_branch_addr),
        .i_jump_addr   (i_jump_addr),
        .i_jr_addr     (i_jr_addr),
        .i_instr       (i_instr),
        .o_pc          (o_pc),
        .o_if_id_pc_4  (o_if_id_pc_4),
        .o_if_id_instr (o_if_id_instr),
        .o_if_id_valid (o_if_id_valid),
        .o_halt        (o_halt),
        .o_fetch_count (o_fetch_count)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] imem(input logic [31:0] addr);
        case (addr)
            32'h0:   return IA;
            32'h4:   return IB;
            32'h8:   return IC;
            32'h10:  return HALT;
            default: return addr + 32'h1000_0000;
        endcase
    endfunction

    assign i_pc_4 = o_pc + 32'd4;
    always_comb i_instr = imem(o_pc);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] p4,
                             input logic [31:0] ins, input logic vld, input logic hlt,
                             input logic [15:0] cnt);
        chk({tag, ".pc"},    o_pc, pc);
        chk({tag, ".pc4"},   o_if_id_pc_4, p4);
        chk({tag, ".instr"}, o_if_id_instr, ins);
        chk({tag, ".valid"}, {31'b0, o_if_id_valid}, {31'b0, vld});
        chk({tag, ".halt"},  {31'b0, o_halt}, {31'b0, hlt});
        chk({tag, ".count"}, {16'b0, o_fetch_count}, {16'b0, cnt});
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_reset = 1'b0; i_enable = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
        i_pc_src = 2'b00; i_branch_addr = '0; i_jump_addr = '0; i_jr_addr = '0;
        tick(); tick();
        chk_state("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
        i_reset = 1'b1;

        // Disabled cycle with flush requested: nothing moves
        i_flush = 1'b1; i_pc_src = 2'b01; i_branch_addr = 32'h80;
        tick();
        chk_state("dis_flush0", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
        i_flush = 1'b0; i_pc_src = 2'b00;

        // Sequential fetch
        i_enable = 1'b1;
        tick(); chk_state("seqA", 32'h4, 32'h4, IA, 1'b1, 1'b0, 16'd1);
        tick(); chk_state("seqB", 32'h8, 32'h8, IB, 1'b1, 1'b0, 16'd2);

        // Stall two cycles at 0x8
        i_stall = 1'b1;
        tick(); chk_state("stall1", 32'h8, 32'h8, IB, 1'b1, 1'b0, 16'd2);
        tick(); chk_state("stall2", 32'h8, 32'h8, IB, 1'b1, 1'b0, 16'd2);
        i_stall = 1'b0;
        tick(); chk_state("seqC", 32'hC, 32'hC, IC, 1'b1, 1'b0, 16'd3);

        // Branch flush while stalled: redirect still taken
        i_pc_src = 2'b01; i_branch_addr = 32'h40; i_flush = 1'b1; i_stall = 1'b1;
        tick(); chk_state("brflush", 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 16'd3);
        i_flush = 1'b0; i_stall = 1'b0;

        // Jump-register then jump
        i_pc_src = 2'b11; i_jr_addr = 32'h100;
        tick(); chk_state("jr", 32'h100, 32'h44, 32'h1000_0040, 1'b1, 1'b0, 16'd4);
        i_pc_src = 2'b10; i_jump_addr = 32'h200;
        tick(); chk_state("jump", 32'h200, 32'h104, 32'h1000_0100, 1'b1, 1'b0, 16'd5);

        // PC wrap at the top of the address space
        i_jump_addr = 32'hFFFF_FFFC;
        tick(); chk_state("tojtop", 32'hFFFF_FFFC, 32'h204, 32'h1000_0200, 1'b1, 1'b0, 16'd6);
        i_pc_src = 2'b00;
        tick(); chk_state("wrap", 32'h0, 32'h0, 32'h0FFF_FFFC, 1'b1, 1'b0, 16'd7);

        // Single-step: one-cycle enable pulse advances exactly one instruction
        i_enable = 1'b0;
        tick(); chk_state("idle", 32'h0, 32'h0, 32'h0FFF_FFFC, 1'b1, 1'b0, 16'd7);
        i_enable = 1'b1;
        tick(); chk_state("step", 32'h4, 32'h4, IA, 1'b1, 1'b0, 16'd8);
        i_enable = 1'b0;
        tick(); chk_state("stephold", 32'h4, 32'h4, IA, 1'b1, 1'b0, 16'd8);

        // Disabled flush mid-run is ignored
        i_flush = 1'b1; i_pc_src = 2'b01; i_branch_addr = 32'h80;
        tick(); chk_state("dis_flush1", 32'h4, 32'h4, IA, 1'b1, 1'b0, 16'd8);
        i_flush = 1'b0;

        // Reach 0x10 and fetch HALT
        i_enable = 1'b1; i_pc_src = 2'b10; i_jump_addr = 32'h10;
        tick(); chk_state("to10", 32'h10, 32'h8, IB, 1'b1, 1'b0, 16'd9);
        i_pc_src = 2'b00;
        tick(); chk_state("halt", 32'h10, 32'h14, HALT, 1'b1, 1'b1, 16'd10);
        tick(); chk_state("halted1", 32'h10, 32'h0, 32'h0, 1'b0, 1'b1, 16'd10);
        i_pc_src = 2'b10; i_jump_addr = 32'h300;
        tick(); chk_state("halted2", 32'h10, 32'h0, 32'h0, 1'b0, 1'b1, 16'd10);

        // Flush while halted: PC stays frozen
        i_flush = 1'b1; i_pc_src = 2'b01; i_branch_addr = 32'h40;
        tick(); chk_state("haltflush", 32'h10, 32'h0, 32'h0, 1'b0, 1'b1, 16'd10);
        i_flush = 1'b0;

        // Asynchronous reset between edges while halted
        i_reset = 1'b0;
        #2;
        chk_state("areset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 16'd0);
        i_reset = 1'b1; i_pc_src = 2'b00;
        tick(); chk_state("postrst", 32'h4, 32'h4, IA, 1'b1, 1'b0, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
